// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package regfile_pkg;

    localparam int unsigned RF_DATA_W   = 64;
    localparam int unsigned RF_NUM_REGS = 32;
    localparam int unsigned RF_ADDR_W   = $clog2(RF_NUM_REGS);

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    // Index width for a given register count; never narrower than one bit.
    function automatic int unsigned rf_addr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: read, write and reserve lanes.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned NUM_WR   = 2
) ();

    localparam int unsigned ADDR_W = rf_addr_bits(NUM_REGS);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [NUM_REGS-1:0]      busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_bypass_mux.sv
// Per-read-port write-first bypass: the highest-index matching write lane wins.
module regfile_bypass_mux #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_WR = 2
) (
    input  logic [ADDR_W-1:0]        i_rd_addr,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic [DATA_W-1:0]        i_mem_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_hit
);

    always_comb begin
        o_data = i_mem_data;
        o_hit  = 1'b0;
        // Ascending scan so a later (higher) lane overrides an earlier match.
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == i_rd_addr)) begin
                o_data = i_wr_data[j*DATA_W +: DATA_W];
                o_hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and a per-register busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = rf_addr_bits(NUM_REGS),
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned NUM_WR   = 2
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);

    localparam logic [ADDR_W:0] REGS_LIM = (ADDR_W+1)'(NUM_REGS);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < REGS_LIM);
    endfunction

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;

    logic [NUM_WR-1:0]   w_wr_ok;
    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_rsv_hit;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_rsv_ok;

    // Out-of-range lanes are dropped here so neither storage nor bypass sees them.
    always_comb begin
        w_wr_ok = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            w_wr_ok[j] = bus.wr_en[j] && addr_ok(bus.wr_addr[j*ADDR_W +: ADDR_W]);
        end
    end

    assign w_rsv_ok = bus.rsv_en && addr_ok(bus.rsv_addr);

    always_comb begin
        w_wr_hit  = '0;
        w_rsv_hit = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    w_wr_hit[r] = 1'b1;
                end
            end
            w_rsv_hit[r] = w_rsv_ok && (bus.rsv_addr == ADDR_W'(r));
        end
    end

    // A reserve in the same cycle as a release means a newer producer: stay busy.
    assign w_busy_nxt = (r_busy & ~w_wr_hit) | w_rsv_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_mem[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j]) begin
                    r_mem[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_ra_ok;
        logic [DATA_W-1:0] w_stored;
        logic [DATA_W-1:0] w_data;
        logic              w_hit;

        assign w_ra     = bus.rd_addr[gi*ADDR_W +: ADDR_W];
        assign w_ra_ok  = addr_ok(w_ra);
        assign w_stored = w_ra_ok ? r_mem[w_ra] : '0;

        regfile_bypass_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_mux (
            .i_rd_addr  (w_ra),
            .i_wr_en    (w_wr_ok),
            .i_wr_addr  (bus.wr_addr),
            .i_wr_data  (bus.wr_data),
            .i_mem_data (w_stored),
            .o_data     (w_data),
            .o_hit      (w_hit)
        );

        assign bus.rd_data[gi*DATA_W +: DATA_W] = reset ? '0 : w_data;
        assign bus.rd_busy[gi] = ~reset & w_ra_ok & r_busy[w_ra] & ~w_hit;
    end

    assign bus.busy_vec = r_busy;

endmodule
